// File: rtl/wb_burst_reader_pkg.sv
// Shared definitions for wb_burst_reader: state encoding and the FIFO pointer-width helper.
package wb_burst_reader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_GAP  = ST_GAP
    } state_e;

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_burst_reader_fifo.sv
// Synchronous FIFO holding words read from the bus until the stream consumer takes them.
module wb_burst_reader_fifo
    import wb_burst_reader_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = ptrWidth(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [PW:0]   count_o
);

    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [PW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign count_o     = count_q;
    assign head_data_o = mem_q[rdPtr_q];

    // A pop frees a slot in the same edge, so push is also allowed when full and popping.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone classic block reader streaming LEN words through a FIFO.
// Define WB_BURST_READER_ERR_EN to add the wb_err_i abort path.
module wb_burst_reader
    import wb_burst_reader_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_n_i,
    input  logic              start_i,
    input  logic [AW-1:0]     base_adr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic              wb_we_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
`ifdef WB_BURST_READER_ERR_EN
    input  logic              wb_err_i,
`endif
    output logic [DW-1:0]     m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i
);

    localparam int PW = ptrWidth(FIFO_DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cyc_q, cyc_d;

    logic             fifoPush;
    logic             fifoEmpty;
    logic             fifoFull;
    logic [PW:0]      fifoCount;
    logic             busErr;

`ifdef WB_BURST_READER_ERR_EN
    assign busErr = wb_err_i;
`else
    assign busErr = 1'b0;
`endif

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign wb_adr_o  = adr_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_dat_o  = '0;
    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = '1;
    assign m_valid_o = !fifoEmpty;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_n_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            remain_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            remain_q <= remain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        remain_d = remain_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fifoPush = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        adr_d    = base_adr_i;
                        remain_d = len_i;
                        busy_d   = 1'b1;
                        state_d  = fifoFull ? S_GAP : S_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // Error wins over a simultaneous ack; the word is dropped.
                if (busErr) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    fifoPush = 1'b1;
                    adr_d    = adr_q + AW'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (fifoCount < (PW+1)'(FIFO_DEPTH)) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cyc_d = (state_d == S_REQ);
    end

    wb_burst_reader_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (wb_clk_i),
        .reset_n_i   (wb_reset_n_i),
        .push_i      (fifoPush),
        .push_data_i (wb_dat_i),
        .pop_i       (m_ready_i),
        .head_data_o (m_data_o),
        .empty_o     (fifoEmpty),
        .full_o      (fifoFull),
        .count_o     (fifoCount)
    );

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader with an SRAM responder and a queue-based reference model.
module tb_wb_burst_reader;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LEN_W = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             resetN;
    logic             start;
    logic [AW-1:0]    baseAdr;
    logic [LEN_W-1:0] len;
    logic             busy, done, errOut;
    logic [AW-1:0]    adr;
    logic [DW-1:0]    wbDatOut;
    logic             we;
    logic [DW/8-1:0]  sel;
    logic             cyc, stb;
    logic             ack, werr;
    logic [DW-1:0]    rdData;
    logic [DW-1:0]    mData;
    logic             mValid;
    logic             mReady;

    always #5 clk = ~clk;

    wb_burst_reader #(
        .AW(AW), .DW(DW), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .wb_clk_i     (clk),
        .wb_reset_n_i (resetN),
        .start_i      (start),
        .base_adr_i   (baseAdr),
        .len_i        (len),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (errOut),
        .wb_adr_o     (adr),
        .wb_dat_o     (wbDatOut),
        .wb_we_o      (we),
        .wb_sel_o     (sel),
        .wb_cyc_o     (cyc),
        .wb_stb_o     (stb),
        .wb_ack_i     (ack),
        .wb_dat_i     (rdData),
`ifdef WB_BURST_READER_ERR_EN
        .wb_err_i     (werr),
`endif
        .m_data_o     (mData),
        .m_valid_o    (mValid),
        .m_ready_i    (mReady)
    );

    // SRAM responder: registered ack gated on ~ack, optional error on the errAt-th read
    logic [DW-1:0] mem [256];
    int            readIdx;
    int            errAt = 0;

    always @(posedge clk) begin
        if (!resetN) begin
            ack     <= 1'b0;
            werr    <= 1'b0;
            readIdx <= 0;
        end else if (cyc && stb && !ack && !werr) begin
            if (errAt != 0 && readIdx + 1 == errAt) begin
                werr <= 1'b1;
            end else begin
                ack    <= 1'b1;
                rdData <= mem[adr];
            end
            readIdx <= readIdx + 1;
        end else begin
            ack  <= 1'b0;
            werr <= 1'b0;
            if (!busy) readIdx <= 0;
        end
    end

    int compared   = 0;
    int mismatched = 0;
    int readyMode  = 2;

    logic [DW-1:0] gotData[$];
    logic [DW-1:0] expData[$];
    logic [AW-1:0] gotAdr[$];
    logic [AW-1:0] expAdr[$];
    int            doneCount;
    logic          lastErr;
    int            gapViol;
    logic          prevAck;

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        int            mode;
        int            expAcks;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Observe one cycle's outputs, then advance to just after the next rising edge
    task automatic stepCycle();
        if (mValid && mReady) gotData.push_back(mData);
        if (cyc && stb && ack) gotAdr.push_back(adr);
        if (prevAck && cyc) gapViol++;
        prevAck = cyc && stb && ack;
        if (done) begin
            doneCount++;
            lastErr = errOut;
        end
        @(posedge clk);
        #1;
        case (readyMode)
            0:       mReady = 1'b1;
            1:       mReady = 1'($urandom_range(0, 1));
            default: mReady = 1'b0;
        endcase
    endtask

    task automatic clearMon();
        gotData.delete();
        gotAdr.delete();
        expData.delete();
        expAdr.delete();
        doneCount = 0;
        lastErr   = 1'b0;
        gapViol   = 0;
        prevAck   = 1'b0;
    endtask

    // Reference: word i of a transfer comes from mem[(base + i) mod 256]
    task automatic buildModel(input logic [AW-1:0] base, input int nWords);
        logic [AW-1:0] a;
        for (int i = 0; i < nWords; i++) begin
            a = base + AW'(i);
            expAdr.push_back(a);
            expData.push_back(mem[a]);
        end
    endtask

    task automatic applyStimulus(input logic [AW-1:0] base, input int n);
        start   = 1'b1;
        baseAdr = base;
        len     = LEN_W'(n);
        stepCycle();
        start   = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int i;
        for (i = 0; i < budget && doneCount == 0; i++) stepCycle();
        if (doneCount == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done timeout: got no done_o within %0d cycles, expected one", budget);
        end
    endtask

    task automatic drain();
        readyMode = 0;
        mReady    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            stepCycle();
            if (!mValid && i > 2) break;
        end
    endtask

    task automatic checkStream(input string name);
        int bad = -1;
        checkOutput({name, " words"}, 64'(gotData.size()), 64'(expData.size()));
        checkOutput({name, " acks"}, 64'(gotAdr.size()), 64'(expAdr.size()));
        for (int i = 0; i < gotData.size() && i < expData.size(); i++)
            if (gotData[i] !== expData[i] && bad < 0) bad = i;
        for (int i = 0; i < gotAdr.size() && i < expAdr.size(); i++)
            if (gotAdr[i] !== expAdr[i] && bad < 0) bad = i + 1000;
        compared++;
        if (bad >= 0) begin
            mismatched++;
            $display("[TB] FAIL %s order: got mismatch at index %0d, expected none", name, bad);
        end
    endtask

    task automatic runTransfer(input string name, input logic [AW-1:0] base, input int n, input int mode, input int expAcks);
        clearMon();
        buildModel(base, n);
        readyMode = mode;
        applyStimulus(base, n);
        waitDone(n * 40 + 50);
        drain();
        checkStream(name);
        checkOutput({name, " exp acks"}, 64'(gotAdr.size()), 64'(expAcks));
        checkOutput({name, " done count"}, 64'(doneCount), 64'd1);
        checkOutput({name, " err"}, 64'(lastErr), 64'd0);
        checkOutput({name, " gap"}, 64'(gapViol), 64'd0);
        checkOutput({name, " busy end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'hA0 + 32'(i);

        vecs[0] = '{8'h10, 4, 0, 4};
        vecs[1] = '{8'hFE, 4, 0, 4};
        vecs[2] = '{8'h80, 1, 1, 1};
        vecs[3] = '{8'h33, 7, 1, 7};
        vecs[4] = '{8'h00, 0, 0, 0};
        vecs[5] = '{8'hF0, 16, 1, 16};

        clearMon();
        resetN = 1'b0; start = 1'b0; baseAdr = '0; len = '0; mReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 0);
        checkOutput("reset done", 64'(done), 0);
        checkOutput("reset err", 64'(errOut), 0);
        checkOutput("reset cyc", 64'(cyc), 0);
        checkOutput("reset stb", 64'(stb), 0);
        checkOutput("reset valid", 64'(mValid), 0);
        checkOutput("reset adr", 64'(adr), 0);
        checkOutput("const we", 64'(we), 0);
        checkOutput("const sel", 64'(sel), 64'hF);
        checkOutput("const dat", 64'(wbDatOut), 0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Latency: start at edge N -> cyc after N, first word valid after N+2
        start = 1'b1; baseAdr = 8'h10; len = 16'd1;
        @(posedge clk); #1; start = 1'b0;
        checkOutput("lat cyc", 64'(cyc), 1);
        checkOutput("lat adr", 64'(adr), 64'h10);
        checkOutput("lat busy", 64'(busy), 1);
        @(posedge clk); #1;
        checkOutput("lat valid early", 64'(mValid), 0);
        @(posedge clk); #1;
        checkOutput("lat valid", 64'(mValid), 1);
        checkOutput("lat data", 64'(mData), 64'hA0);
        checkOutput("lat done", 64'(done), 1);
        checkOutput("lat cyc end", 64'(cyc), 0);
        drain();
        checkOutput("lat drained", 64'(mValid), 0);

        // Zero length: done next cycle, no bus cycle
        start = 1'b1; baseAdr = 8'h22; len = '0;
        @(posedge clk); #1; start = 1'b0;
        checkOutput("zero done", 64'(done), 1);
        checkOutput("zero err", 64'(errOut), 0);
        checkOutput("zero cyc", 64'(cyc), 0);
        checkOutput("zero busy", 64'(busy), 0);
        @(posedge clk); #1;
        checkOutput("zero done pulse", 64'(done), 0);
        checkOutput("zero cyc later", 64'(cyc), 0);

        for (int v = 0; v < 6; v++)
            runTransfer($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].expAcks);

        // Backpressure: 4 reads fill the FIFO, then the bus idles until the consumer drains
        clearMon();
        buildModel(8'h50, 10);
        readyMode = 2;
        applyStimulus(8'h50, 10);
        repeat (40) stepCycle();
        checkOutput("bp acks held", 64'(gotAdr.size()), 64'd4);
        checkOutput("bp cyc held", 64'(cyc), 0);
        checkOutput("bp busy held", 64'(busy), 1);
        checkOutput("bp valid held", 64'(mValid), 1);
        readyMode = 0;
        waitDone(500);
        drain();
        checkStream("bp");
        checkOutput("bp done count", 64'(doneCount), 1);

        // Start while busy is ignored
        clearMon();
        buildModel(8'h30, 3);
        readyMode = 0;
        applyStimulus(8'h30, 3);
        stepCycle();
        applyStimulus(8'h40, 5);
        waitDone(200);
        drain();
        repeat (10) stepCycle();
        checkStream("busy start");
        checkOutput("busy start done", 64'(doneCount), 1);

        // Reset after the 2nd ack of an 8-word transfer
        clearMon();
        readyMode = 0;
        applyStimulus(8'h20, 8);
        for (int i = 0; i < 100 && gotAdr.size() < 2; i++) stepCycle();
        resetN = 1'b0;
        stepCycle();
        checkOutput("rst cyc", 64'(cyc), 0);
        checkOutput("rst stb", 64'(stb), 0);
        checkOutput("rst busy", 64'(busy), 0);
        checkOutput("rst valid", 64'(mValid), 0);
        checkOutput("rst done", 64'(done), 0);
        resetN = 1'b1;
        repeat (5) stepCycle();
        checkOutput("rst no done", 64'(doneCount), 0);
        checkOutput("rst idle cyc", 64'(cyc), 0);
        runTransfer("after rst", 8'h20, 8, 0, 8);

`ifdef WB_BURST_READER_ERR_EN
        // Bus error on the 3rd read of 5: two words kept, done with err
        clearMon();
        buildModel(8'h60, 2);
        errAt = 3;
        readyMode = 0;
        applyStimulus(8'h60, 5);
        waitDone(200);
        checkOutput("err flag", 64'(lastErr), 1);
        checkOutput("err busy", 64'(busy), 0);
        drain();
        checkStream("err");
        checkOutput("err done count", 64'(doneCount), 1);
        errAt = 0;
`endif

        for (int r = 0; r < 12; r++) begin
            logic [AW-1:0] b;
            int            n;
            b = AW'($urandom_range(0, 255));
            n = $urandom_range(0, 12);
            runTransfer($sformatf("rand%0d", r), b, n, $urandom_range(0, 1), n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
